// File: rtl/fcap_pkg.sv
// Shared types and bit-search helpers for the filter-capacitor bank sequencer.
package fcap_pkg;

   localparam int MAX_BANKS       = 16;
   localparam int IDX_W           = 5;
   localparam int STEP_CYCLES_DEF = 16;

   // Index value returned when a search finds no set bit.
   localparam logic [IDX_W-1:0] NO_BIT = IDX_W'(MAX_BANKS);

   typedef enum logic [1:0] {
      IDLE,
      UP,
      ON,
      DOWN
   } fcap_state_e;

   // Lowest set bit of mask at position idx or higher; NO_BIT if none.
   function automatic logic [IDX_W-1:0] lowest_set_above(input logic [MAX_BANKS-1:0] mask,
                                                         input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] result;
      result = NO_BIT;
      for (int i = MAX_BANKS - 1; i >= 0; i--) begin
         if (mask[i] && (IDX_W'(i) >= idx)) begin
            result = IDX_W'(i);
         end
      end
      return result;
   endfunction

   function automatic logic [IDX_W-1:0] highest_set(input logic [MAX_BANKS-1:0] vec);
      logic [IDX_W-1:0] result;
      result = NO_BIT;
      for (int i = 0; i < MAX_BANKS; i++) begin
         if (vec[i]) begin
            result = IDX_W'(i);
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/fcap_step_timer.sv
// Dwell counter: loads a start value, counts down to zero and holds there.
module fcap_step_timer #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/filter_cap_bank_seq.sv
// Sequences DVDD filter-capacitor banks on and off one at a time with a dwell
// between switch events to bound inrush current and rail droop.
module filter_cap_bank_seq
   import fcap_pkg::*;
#(
   parameter int N_BANKS     = 3,
   parameter int STEP_CYCLES = STEP_CYCLES_DEF,
   parameter int CNT_W       = $clog2(STEP_CYCLES + 1)
) (
   input  logic               CLK,
   input  logic               rst_b,
   input  logic               en,
   input  logic [N_BANKS-1:0] bank_mask,
   output logic [N_BANKS-1:0] bank_en,
   output logic               busy,
   output logic               ready,
   output logic [N_BANKS-1:0] active_mask
);

   generate
      if (N_BANKS < 1 || N_BANKS > MAX_BANKS || STEP_CYCLES < 1) begin : g_param_check
         $error("filter_cap_bank_seq: N_BANKS must be 1..16 and STEP_CYCLES >= 1");
      end
   endgenerate

   fcap_state_e        state_q, state_d;
   logic [N_BANKS-1:0] bank_en_q, bank_en_d;
   logic [N_BANKS-1:0] active_mask_q, active_mask_d;
   logic [IDX_W-1:0]   index_q, index_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               dwell_load;
   logic               dwell_zero;

   logic [IDX_W-1:0]   first_bit, next_bit, top_bit, refill_bit;
   logic [N_BANKS-1:0] first_oh, next_oh, top_oh, refill_oh;

   // Candidate switch events: first bank of a new ramp, next bank up, bank to
   // drop on the way down, and the lowest re-connectable bank after a reversal.
   assign first_bit  = lowest_set_above(MAX_BANKS'(bank_mask), '0);
   assign next_bit   = lowest_set_above(MAX_BANKS'(active_mask_q), index_q + IDX_W'(1));
   assign top_bit    = highest_set(MAX_BANKS'(bank_en_q));
   assign refill_bit = lowest_set_above(MAX_BANKS'(active_mask_q & ~bank_en_q), '0);

   assign first_oh  = N_BANKS'(1) << first_bit;
   assign next_oh   = N_BANKS'(1) << next_bit;
   assign top_oh    = N_BANKS'(1) << top_bit;
   assign refill_oh = N_BANKS'(1) << refill_bit;

   fcap_step_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (CLK),
      .rst_b   (rst_b),
      .load    (dwell_load),
      .load_val(CNT_W'(STEP_CYCLES - 1)),
      .zero    (dwell_zero)
   );

   // The en level is tested before dwell expiry so a direction change always
   // wins over a step in the old direction.
   always_comb begin
      state_d       = state_q;
      bank_en_d     = bank_en_q;
      active_mask_d = active_mask_q;
      index_d       = index_q;
      busy_d        = busy_q;
      ready_d       = ready_q;
      dwell_load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (en) begin
               active_mask_d = bank_mask;
               if (first_bit == NO_BIT) begin
                  state_d = ON;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d    = UP;
                  index_d    = first_bit;
                  bank_en_d  = bank_en_q | first_oh;
                  dwell_load = 1'b1;
                  busy_d     = 1'b1;
               end
            end
         end
         UP: begin
            if (!en) begin
               state_d    = DOWN;
               bank_en_d  = bank_en_q & ~top_oh;
               dwell_load = 1'b1;
            end else if (dwell_zero) begin
               if (next_bit == NO_BIT) begin
                  state_d = ON;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  index_d    = next_bit;
                  bank_en_d  = bank_en_q | next_oh;
                  dwell_load = 1'b1;
               end
            end
         end
         ON: begin
            if (!en) begin
               ready_d = 1'b0;
               if (top_bit == NO_BIT) begin
                  state_d = IDLE;
               end else begin
                  state_d    = DOWN;
                  bank_en_d  = bank_en_q & ~top_oh;
                  dwell_load = 1'b1;
                  busy_d     = 1'b1;
               end
            end
         end
         DOWN: begin
            if (en) begin
               if (refill_bit == NO_BIT) begin
                  state_d = ON;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d    = UP;
                  index_d    = refill_bit;
                  bank_en_d  = bank_en_q | refill_oh;
                  dwell_load = 1'b1;
               end
            end else if (dwell_zero) begin
               if (top_bit == NO_BIT) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  bank_en_d  = bank_en_q & ~top_oh;
                  dwell_load = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= IDLE;
         bank_en_q     <= '0;
         active_mask_q <= '0;
         index_q       <= '0;
         busy_q        <= 1'b0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         bank_en_q     <= bank_en_d;
         active_mask_q <= active_mask_d;
         index_q       <= index_d;
         busy_q        <= busy_d;
         ready_q       <= ready_d;
      end
   end

   assign bank_en     = bank_en_q;
   assign busy        = busy_q;
   assign ready       = ready_q;
   assign active_mask = active_mask_q;

endmodule

// File: tb/tb_filter_cap_bank_seq.sv
// Directed bench for filter_cap_bank_seq with three banks and a four-cycle dwell.
module tb_filter_cap_bank_seq;

   localparam int N = 3;
   localparam int S = 4;

   logic         CLK = 1'b0;
   logic         rst_b;
   logic         en;
   logic [N-1:0] bank_mask;
   logic [N-1:0] bank_en;
   logic [N-1:0] active_mask;
   logic         busy;
   logic         ready;

   int n_tests = 0;
   int n_fail  = 0;

   filter_cap_bank_seq #(
      .N_BANKS    (N),
      .STEP_CYCLES(S)
   ) dut (
      .CLK        (CLK),
      .rst_b      (rst_b),
      .en         (en),
      .bank_mask  (bank_mask),
      .bank_en    (bank_en),
      .busy       (busy),
      .ready      (ready),
      .active_mask(active_mask)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      rst_b     = 1'b0;
      en        = 1'b0;
      bank_mask = 3'b111;
      tick();
      tick();
      n_tests++;
      if (bank_en !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL reset bank_en: got %b expected 000", bank_en);
      end
      n_tests++;
      if (busy !== 1'b0 || ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset busy/ready: got %b/%b expected 0/0", busy, ready);
      end
      n_tests++;
      if (active_mask !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL reset active_mask: got %b expected 000", active_mask);
      end
      rst_b = 1'b1;
      tick();
   endtask

   task automatic test_ramp_up();
      logic [N-1:0] exp_en;
      logic         exp_busy;
      logic         exp_ready;
      bank_mask = 3'b111;
      en        = 1'b1;
      for (int e = 0; e <= 3 * S; e++) begin
         tick();
         exp_en    = (e < S) ? 3'b001 : (e < 2 * S) ? 3'b011 : 3'b111;
         exp_busy  = (e < 3 * S);
         exp_ready = (e >= 3 * S);
         n_tests++;
         if (bank_en !== exp_en || busy !== exp_busy || ready !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL ramp_up edge %0d: got en=%b busy=%b ready=%b expected en=%b busy=%b ready=%b",
                     e, bank_en, busy, ready, exp_en, exp_busy, exp_ready);
         end
      end
      n_tests++;
      if (active_mask !== 3'b111) begin
         n_fail++;
         $display("[TB] FAIL ramp_up active_mask: got %b expected 111", active_mask);
      end
   endtask

   task automatic test_mask_change_on();
      bank_mask = 3'b010;
      for (int e = 0; e < 3; e++) begin
         tick();
         n_tests++;
         if (bank_en !== 3'b111 || active_mask !== 3'b111 || ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mask_change_on cycle %0d: got en=%b act=%b ready=%b expected 111/111/1",
                     e, bank_en, active_mask, ready);
         end
      end
   endtask

   task automatic test_ramp_down();
      logic [N-1:0] exp_en;
      logic         exp_busy;
      en = 1'b0;
      for (int e = 0; e <= 3 * S; e++) begin
         tick();
         exp_en   = (e < S) ? 3'b011 : (e < 2 * S) ? 3'b001 : 3'b000;
         exp_busy = (e < 3 * S);
         n_tests++;
         if (bank_en !== exp_en || busy !== exp_busy || ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL ramp_down edge %0d: got en=%b busy=%b ready=%b expected en=%b busy=%b ready=0",
                     e, bank_en, busy, ready, exp_en, exp_busy);
         end
      end
   endtask

   task automatic test_masked_ramp();
      logic [N-1:0] exp_en;
      bank_mask = 3'b101;
      en        = 1'b1;
      for (int e = 0; e <= 2 * S; e++) begin
         tick();
         exp_en = (e < S) ? 3'b001 : 3'b101;
         n_tests++;
         if (bank_en !== exp_en || busy !== (e < 2 * S) || ready !== (e >= 2 * S)) begin
            n_fail++;
            $display("[TB] FAIL masked_ramp edge %0d: got en=%b busy=%b ready=%b expected en=%b",
                     e, bank_en, busy, ready, exp_en);
         end
      end
      n_tests++;
      if (active_mask !== 3'b101) begin
         n_fail++;
         $display("[TB] FAIL masked_ramp active_mask: got %b expected 101", active_mask);
      end
      en = 1'b0;
      for (int e = 0; e <= 2 * S; e++) begin
         tick();
         exp_en = (e < S) ? 3'b001 : 3'b000;
         n_tests++;
         if (bank_en !== exp_en || busy !== (e < 2 * S)) begin
            n_fail++;
            $display("[TB] FAIL masked_down edge %0d: got en=%b busy=%b expected en=%b busy=%b",
                     e, bank_en, busy, exp_en, (e < 2 * S));
         end
      end
   endtask

   task automatic test_reversal();
      logic [N-1:0] exp_en;
      int           r;
      // Part A: reverse after bank 1 connects and run all the way back to idle.
      bank_mask = 3'b111;
      en        = 1'b1;
      for (int e = 0; e <= S + 1; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b011) begin
         n_fail++;
         $display("[TB] FAIL reversal_pre bank_en: got %b expected 011", bank_en);
      end
      en = 1'b0;
      for (int e = S + 2; e <= 3 * S + 2; e++) begin
         tick();
         exp_en = (e < 2 * S + 2) ? 3'b001 : 3'b000;
         n_tests++;
         if (bank_en !== exp_en || busy !== (e < 3 * S + 2) || ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reversal_down edge %0d: got en=%b busy=%b ready=%b expected en=%b busy=%b",
                     e, bank_en, busy, ready, exp_en, (e < 3 * S + 2));
         end
      end
      // Part B: same reversal, then re-request during the dwell after the last clear.
      en = 1'b1;
      for (int e = 0; e <= S + 1; e++) begin
         tick();
      end
      en = 1'b0;
      for (int e = S + 2; e <= 2 * S + 3; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b000 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL reversal_dwell: got en=%b busy=%b expected 000/1", bank_en, busy);
      end
      en = 1'b1;
      for (int e = 2 * S + 4; e <= 5 * S + 4; e++) begin
         tick();
         r      = e - (2 * S + 4);
         exp_en = (r < S) ? 3'b001 : (r < 2 * S) ? 3'b011 : 3'b111;
         n_tests++;
         if (bank_en !== exp_en || busy !== (r < 3 * S) || ready !== (r >= 3 * S)) begin
            n_fail++;
            $display("[TB] FAIL reversal_up edge %0d: got en=%b busy=%b ready=%b expected en=%b",
                     e, bank_en, busy, ready, exp_en);
         end
      end
      en = 1'b0;
      for (int e = 0; e <= 3 * S; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b000 || busy !== 1'b0 || ready !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reversal_idle: got en=%b busy=%b ready=%b expected 000/0/0", bank_en, busy, ready);
      end
   endtask

   task automatic test_same_cycle();
      bank_mask = 3'b111;
      en        = 1'b1;
      for (int e = 0; e < S; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b001) begin
         n_fail++;
         $display("[TB] FAIL same_cycle_pre bank_en: got %b expected 001", bank_en);
      end
      en = 1'b0;
      tick();
      n_tests++;
      if (bank_en !== 3'b000 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL same_cycle_expiry: got en=%b busy=%b expected 000/1", bank_en, busy);
      end
      for (int e = 0; e < S; e++) begin
         tick();
      end
      n_tests++;
      if (busy !== 1'b0 || bank_en !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL same_cycle_idle: got en=%b busy=%b expected 000/0", bank_en, busy);
      end
   endtask

   task automatic test_zero_mask();
      bank_mask = 3'b000;
      en        = 1'b1;
      tick();
      n_tests++;
      if (ready !== 1'b1 || busy !== 1'b0 || bank_en !== 3'b000 || active_mask !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL zero_mask: got ready=%b busy=%b en=%b act=%b expected 1/0/000/000",
                  ready, busy, bank_en, active_mask);
      end
      bank_mask = 3'b111;
      for (int e = 0; e < 3; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b000 || active_mask !== 3'b000 || ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL zero_mask_change: got en=%b act=%b ready=%b expected 000/000/1",
                  bank_en, active_mask, ready);
      end
      en = 1'b0;
      tick();
      n_tests++;
      if (ready !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL zero_mask_off: got ready=%b busy=%b expected 0/0", ready, busy);
      end
   endtask

   task automatic test_async_reset();
      bank_mask = 3'b111;
      en        = 1'b1;
      for (int e = 0; e <= S + 1; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b011) begin
         n_fail++;
         $display("[TB] FAIL async_pre bank_en: got %b expected 011", bank_en);
      end
      #2;
      rst_b = 1'b0;
      #1;
      n_tests++;
      if (bank_en !== 3'b000 || busy !== 1'b0 || ready !== 1'b0 || active_mask !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got en=%b busy=%b ready=%b act=%b expected 000/0/0/000",
                  bank_en, busy, ready, active_mask);
      end
      tick();
      rst_b = 1'b1;
      tick();
      n_tests++;
      if (bank_en !== 3'b001 || busy !== 1'b1 || active_mask !== 3'b111) begin
         n_fail++;
         $display("[TB] FAIL async_restart: got en=%b busy=%b act=%b expected 001/1/111",
                  bank_en, busy, active_mask);
      end
      for (int e = 1; e <= S; e++) begin
         tick();
      end
      n_tests++;
      if (bank_en !== 3'b011) begin
         n_fail++;
         $display("[TB] FAIL async_restart_step: got %b expected 011", bank_en);
      end
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_mask_change_on();
      test_ramp_down();
      test_masked_ramp();
      test_reversal();
      test_same_cycle();
      test_zero_mask();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/filter_cap_bank_seq.md
Name: filter_cap_bank_seq

Overview:
- Parametrised sequencer for switchable on-chip supply filter-capacitor banks (DVDD domain).
- Supersedes the static, always-connected filter-cap cells. Banks are connected one at a time with a programmable dwell between steps, which limits inrush current and supply droop on the digital rail.
- Disconnects banks in reverse order on request and reports when the rail is fully filtered.
- Sits beside the power-management logic and drives the cap-bank switch enables.

Parameters:
- N_BANKS, 3, number of switchable capacitor banks (1..16).
- STEP_CYCLES, 16, clock cycles of dwell after each bank change (>=1).
- CNT_W, $clog2(STEP_CYCLES+1), width of the dwell counter.

Ports:
- CLK  input  1  system clock.
- rst_b  input  1  asynchronous active-low reset.
- en  input  1  level request: 1 connects the banks, 0 disconnects them.
- bank_mask  input  N_BANKS  banks permitted to connect; latched at the start of each ramp-up.
- bank_en  output  N_BANKS  switch enables, bit i = bank i connected.
- busy  output  1  high during ramp-up or ramp-down.
- ready  output  1  high in the ON state once the final dwell has expired.
- active_mask  output  N_BANKS  mask latched for the current ramp.

Behaviour:
- Reset (async, rst_b=0):
  - bank_en=0, busy=0, ready=0, active_mask=0.
  - state=IDLE, counter=0, index=0.
  - Reset takes effect mid-ramp too: all banks drop immediately. There is no ramp-down on reset.
- All outputs are registered. The FSM states are IDLE, UP, ON, DOWN.
- IDLE:
  - On an edge with en=1: latch active_mask<=bank_mask, go to UP, index<=lowest set bit of the mask.
  - If the mask is 0: go directly to ON with ready=1 on the same edge and busy=0.
- UP:
  - On entry, and at each dwell expiry, set bank_en[index] and load counter<=STEP_CYCLES-1. busy=1.
  - Counter decrements each cycle. When it reaches 0, advance index to the next set bit of active_mask.
  - Cleared mask bits are skipped in zero cycles.
  - After the dwell of the last set bit expires, go to ON.
  - Latency from the en sampling edge to the ready edge is K*STEP_CYCLES, where K is the number of set mask bits.
- ON:
  - ready=1, busy=0. Changes to bank_mask are ignored until the next ramp-up.
  - en=0 goes to DOWN. ready drops on the same edge.
- DOWN:
  - Clear the highest still-set bank_en bit, then dwell STEP_CYCLES. Repeat downward.
  - After the dwell following the last clear, go to IDLE with busy=0.
- Reversal, en=0 during UP:
  - On the next edge, go to DOWN starting from the highest currently set bank.
  - The current dwell is abandoned. The counter reloads on the first clear.
- Reversal, en=1 during DOWN:
  - Go to UP. The next connected bank is the lowest bit of active_mask that is currently off.
  - active_mask is not relatched.
- Same-cycle events:
  - If en toggles on the exact cycle a dwell expires, the direction change wins. No further bank is added or removed in the old direction.
- Invariant: bank_en is always a subset of active_mask, and at most one bit changes per edge.
- Out-of-range parameters (STEP_CYCLES=0, N_BANKS>16) are rejected at elaboration by a generate-time check.

Decomposition:
- Shared package fcap_pkg contains:
  - the state enum (IDLE, UP, ON, DOWN);
  - the functions lowest_set_above(mask, idx) and highest_set(vec);
  - the STEP_CYCLES default constant.
- One sub-module, fcap_step_timer, implements the dwell counter: load, decrement, and a zero flag. It is parametrised by CNT_W.

Test Plan:
- Basic ramp-up (N_BANKS=3, STEP_CYCLES=4, mask=111): en rises.
  - Expect bank_en 001, 011, 111 on edges 0, 4, 8.
  - Expect ready at edge 12; busy high on edges 0..11.
- Masked ramp (mask=101): en rises.
  - Expect bank_en 001 at edge 0, 101 at edge 4, ready at edge 8.
  - Expect bank 1 never asserted and active_mask=101.
- Ramp-down from ON: en falls.
  - Expect ready=0 on the next edge, then bank_en 011, then 001 four cycles later, then 000 four cycles after that.
  - Expect busy=0 and state IDLE 4 cycles after the last clear.
- Reversal during UP (mask=111): drop en 2 cycles after bank_en=011.
  - Expect 001 on the next edge, 000 four cycles later, then IDLE.
  - Then raise en during the DOWN dwell: expect a return to UP, bank_en re-asserts 001 starting from the lowest-off bit.
- Zero mask and mask change while ON:
  - mask=000 with en rising: expect ready on the same edge and bank_en=000.
  - Changing mask in ON must leave bank_en and active_mask unchanged.
- Async reset mid-ramp: pull rst_b low between clock edges during UP.
  - Expect bank_en=000 and busy=ready=0 immediately, with no clock edge needed.
  - After release with en=1: a fresh ramp starts from bank 0.
